// File: rtl/life_pkg.sv
// Shared definitions for the life engine host bridge: register map, JIM key,
// bridge state encoding and the synchronised bus payload.
package life_pkg;

    localparam int unsigned BUS_AW = 8;
    localparam int unsigned BUS_DW = 8;
    localparam int unsigned MEM_AW = 19;

    localparam logic [BUS_AW-1:0] REG_JIM_PAGE = 8'hFF;
    localparam logic [BUS_AW-1:0] REG_JIM_HI   = 8'hFE;
    localparam logic [BUS_AW-1:0] REG_LIFE_A0  = 8'hA0;
    localparam logic [BUS_AW-1:0] REG_LIFE_A1  = 8'hA1;
    localparam logic [BUS_AW-1:0] REG_LIFE_A2  = 8'hA2;
    localparam logic [BUS_AW-1:0] REG_LIFE_A3  = 8'hA3;
    localparam logic [BUS_AW-1:0] REG_LIFE_A4  = 8'hA4;
    localparam logic [BUS_AW-1:0] REG_LIFE_A5  = 8'hA5;
    localparam logic [BUS_AW-1:0] REG_LIFE_A6  = 8'hA6;
    localparam logic [BUS_AW-1:0] REG_LIFE_A7  = 8'hA7;
    localparam logic [BUS_AW-1:0] REG_LIFE_A8  = 8'hA8;

    localparam logic [5:0] JIM_CODE = 6'b110010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    typedef struct packed {
        logic              rnw;
        logic              pgfc_n;
        logic              pgfd_n;
        logic [BUS_AW-1:0] addr;
        logic [BUS_DW-1:0] data;
    } bus_fields_t;

    // SRAM byte address: bank selects one of four 64KB windows, bit 18 unused
    function automatic logic [MEM_AW-1:0] jim_mem_addr(input logic [1:0] bank,
                                                       input logic [BUS_AW-1:0] hi,
                                                       input logic [BUS_AW-1:0] lo);
        return {1'b0, bank, hi, lo};
    endfunction

endpackage

// File: rtl/jim_ram_bridge_if.sv
// Single-request SRAM arbiter port: request held until a one-cycle ack.
interface jim_ram_bridge_if;
    import life_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [BUS_DW-1:0] mem_wdata;
    logic              mem_ack;
    logic [BUS_DW-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/bus_sync.sv
// Brings the asynchronous 1MHz bus into the local clock domain as one group and
// flags clke edges; edges are masked briefly after reset while the chain settles.
module bus_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned W      = 19
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clke,
    input  logic [W-1:0] fields,
    output logic         clke_s,
    output logic         clke_rise_c,
    output logic         clke_fall_c,
    output logic [W-1:0] fields_s,
    output logic [W-1:0] fields_d
);
    logic [W:0] sync_q [STAGES];
    logic [W:0] dly_q;
    logic [1:0] mask_cnt;
    logic       clke_d;

    always_ff @(posedge clk) begin
        sync_q[0] <= {clke, fields};
        for (int unsigned i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
        dly_q <= sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_cnt <= 2'd2;
        end else if (mask_cnt != 2'd0) begin
            mask_cnt <= mask_cnt - 2'd1;
        end
    end

    assign clke_s      = sync_q[STAGES-1][W];
    assign fields_s    = sync_q[STAGES-1][W-1:0];
    assign clke_d      = dly_q[W];
    assign fields_d    = dly_q[W-1:0];
    assign clke_rise_c = (mask_cnt == 2'd0) &&  clke_s && !clke_d;
    assign clke_fall_c = (mask_cnt == 2'd0) && !clke_s &&  clke_d;
endmodule

// File: rtl/jim_ram_bridge.sv
// Host bridge: JIM paging registers FCFF/FCFE, page-FD single-byte SRAM access
// and one-cycle strobes for every other page-FC write.
module jim_ram_bridge
    import life_pkg::*;
#(
    parameter logic [BUS_DW-1:0] RD_FAIL_DATA = 8'hFF,
    parameter int unsigned       SYNC_STAGES  = 2
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              clke,
    input  logic              rnw,
    input  logic              pgfc_n,
    input  logic              pgfd_n,
    input  logic [BUS_AW-1:0] bus_addr,
    input  logic [BUS_DW-1:0] bus_data_in,
    output logic [BUS_DW-1:0] bus_data_out,
    output logic              bus_data_oe,
    output logic              reg_wr,
    output logic [BUS_AW-1:0] reg_addr,
    output logic [BUS_DW-1:0] reg_data,
    jim_ram_bridge_if.master  mem,
    output logic              overrun
);
    bus_fields_t       bus_in, bus_s, bus_d;
    logic              clke_s, clke_rise, clke_fall;
    logic [BUS_DW-1:0] fcff, fcfe;
    state_t            state;
    logic              jim_en, fc_wr, fd_wr, rd_start, fc_rd, fd_rd;
    logic              unused_bits;

    assign bus_in = {rnw, pgfc_n, pgfd_n, bus_addr, bus_data_in};

    bus_sync #(
        .STAGES (SYNC_STAGES),
        .W      ($bits(bus_fields_t))
    ) u_bus_sync (
        .clk         (clk50),
        .rst_n       (rst_n),
        .clke        (clke),
        .fields      (bus_in),
        .clke_s      (clke_s),
        .clke_rise_c (clke_rise),
        .clke_fall_c (clke_fall),
        .fields_s    (bus_s),
        .fields_d    (bus_d)
    );

    // Reads decode on the synchronised bus at clke rise, writes on the delayed copy at clke fall
    assign jim_en   = (fcff[7:2] == JIM_CODE);
    assign fc_wr    = clke_fall && !bus_d.rnw && !bus_d.pgfc_n;
    assign fd_wr    = clke_fall && !bus_d.rnw && !bus_d.pgfd_n && jim_en;
    assign rd_start = clke_rise && bus_s.rnw;
    assign fc_rd    = rd_start && !bus_s.pgfc_n &&
                      ((bus_s.addr == REG_JIM_PAGE) || (bus_s.addr == REG_JIM_HI));
    assign fd_rd    = rd_start && !bus_s.pgfd_n && jim_en;

    assign unused_bits = ^bus_s.data;

    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            state         <= IDLE;
            fcff          <= '0;
            fcfe          <= '0;
            reg_wr        <= 1'b0;
            reg_addr      <= '0;
            reg_data      <= '0;
            bus_data_oe   <= 1'b0;
            bus_data_out  <= '0;
            overrun       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            reg_wr <= 1'b0;
            if (fc_wr) begin
                if (bus_d.addr == REG_JIM_PAGE) begin
                    fcff <= bus_d.data;
                end else if (bus_d.addr == REG_JIM_HI) begin
                    fcfe <= bus_d.data;
                end else begin
                    reg_wr   <= 1'b1;
                    reg_addr <= bus_d.addr;
                    reg_data <= bus_d.data;
                end
            end

            if (clke_fall) begin
                bus_data_oe <= 1'b0;
            end else if (fc_rd) begin
                bus_data_oe  <= 1'b1;
                bus_data_out <= (bus_s.addr == REG_JIM_PAGE) ? fcff : fcfe;
            end else if (fd_rd) begin
                bus_data_oe  <= 1'b1;
                bus_data_out <= RD_FAIL_DATA;
            end

            case (state)
                IDLE: begin
                    if (fd_rd) begin
                        state        <= RD;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= jim_mem_addr(fcff[1:0], fcfe, bus_s.addr);
                    end else if (fd_wr) begin
                        state         <= WR;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= jim_mem_addr(fcff[1:0], fcfe, bus_d.addr);
                        mem.mem_wdata <= bus_d.data;
                    end
                end
                RD: begin
                    if (fd_wr) overrun <= 1'b1;
                    if (mem.mem_ack) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                        // A late byte is dropped: the host has already sampled the fail value
                        if (clke_s) bus_data_out <= mem.mem_rdata;
                    end
                end
                WR: begin
                    if (fd_wr) overrun <= 1'b1;
                    if (mem.mem_ack) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jim_ram_bridge.sv
// Scoreboard bench for jim_ram_bridge: bus cycles push expected SRAM requests,
// register strobes and read bytes; independent monitors pop and compare.
module tb_jim_ram_bridge;
    import life_pkg::*;

    logic       clk50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       clke = 1'b0;
    logic       rnw = 1'b1;
    logic       pgfc_n = 1'b1;
    logic       pgfd_n = 1'b1;
    logic [7:0] bus_addr = 8'h00;
    logic [7:0] bus_data_in = 8'h00;
    logic [7:0] bus_data_out;
    logic       bus_data_oe;
    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       overrun;

    jim_ram_bridge_if mem ();

    jim_ram_bridge dut (
        .clk50        (clk50),
        .rst_n        (rst_n),
        .clke         (clke),
        .rnw          (rnw),
        .pgfc_n       (pgfc_n),
        .pgfd_n       (pgfd_n),
        .bus_addr     (bus_addr),
        .bus_data_in  (bus_data_in),
        .bus_data_out (bus_data_out),
        .bus_data_oe  (bus_data_oe),
        .reg_wr       (reg_wr),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .mem          (mem.master),
        .overrun      (overrun)
    );

    always #10 clk50 = ~clk50;

    typedef struct { logic [18:0] addr; logic we; logic [7:0] wdata; } mem_exp_t;
    typedef struct { logic oe; logic [7:0] data; } rd_exp_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } reg_exp_t;

    mem_exp_t mem_q [$];
    rd_exp_t  rd_q  [$];
    reg_exp_t reg_q [$];

    int   checks = 0;
    int   errors = 0;
    logic cur_read = 1'b0;
    time  fall_t = 0;
    int   ack_delay = 3;
    logic [7:0] ack_rdata = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic [18:0] a, input logic we, input logic [7:0] wd);
        mem_exp_t e;
        e.addr = a; e.we = we; e.wdata = wd;
        mem_q.push_back(e);
    endtask

    task automatic exp_rd(input logic oe, input logic [7:0] d);
        rd_exp_t e;
        e.oe = oe; e.data = d;
        rd_q.push_back(e);
    endtask

    task automatic exp_reg(input logic [7:0] a, input logic [7:0] d);
        reg_exp_t e;
        e.addr = a; e.data = d;
        reg_q.push_back(e);
    endtask

    // One 1MHz bus cycle; fd selects page FD, else page FC
    task automatic bus_cycle(input logic is_rd, input logic fd, input logic [7:0] a, input logic [7:0] d);
        rnw = is_rd; pgfc_n = fd; pgfd_n = !fd; bus_addr = a; bus_data_in = d;
        cur_read = is_rd;
        #100 clke = 1'b1;
        #500 clke = 1'b0;
        #120 pgfc_n = 1'b1; pgfd_n = 1'b1; rnw = 1'b1; cur_read = 1'b0;
        #300;
    endtask

    always @(negedge clke) fall_t = $time;

    // Read-data monitor: host samples the bus as clke falls
    always @(negedge clke) begin
        if (cur_read) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: read cycle with no expectation, oe=%0b", bus_data_oe);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check("rd_oe", 32'(bus_data_oe), 32'(e.oe));
                if (e.oe) check("rd_data", 32'(bus_data_out), 32'(e.data));
            end
            #200 check("oe_drop", 32'(bus_data_oe), 32'd0);
        end
    end

    // SRAM request monitor
    logic req_prev = 1'b0;
    always @(negedge clk50) begin
        if (mem.mem_req && !req_prev) begin
            if (mem_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_unexpected: addr=0x%0h we=%0b", mem.mem_addr, mem.mem_we);
            end else begin
                mem_exp_t e;
                e = mem_q.pop_front();
                check("mem_addr", 32'(mem.mem_addr), 32'(e.addr));
                check("mem_we", 32'(mem.mem_we), 32'(e.we));
                if (e.we) begin
                    check("mem_wdata", 32'(mem.mem_wdata), 32'(e.wdata));
                    check("wr_latency_ok", 32'(($time - fall_t) <= 90), 32'd1);
                end
            end
        end
        req_prev = mem.mem_req;
    end

    // Register strobe monitor
    logic regwr_prev = 1'b0;
    always @(negedge clk50) begin
        if (reg_wr) begin
            check("reg_wr_width", 32'(regwr_prev), 32'd0);
            if (reg_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL reg_unexpected: addr=0x%0h data=0x%0h", reg_addr, reg_data);
            end else begin
                reg_exp_t e;
                e = reg_q.pop_front();
                check("reg_addr", 32'(reg_addr), 32'(e.addr));
                check("reg_data", 32'(reg_data), 32'(e.data));
            end
        end
        regwr_prev = reg_wr;
    end

    // Arbiter model: acks after ack_delay cycles, checks request is held steady
    logic [18:0] arb_addr;
    logic        arb_stable;
    initial begin
        mem.mem_ack = 1'b0;
        mem.mem_rdata = 8'h00;
        forever begin
            @(posedge clk50); #1;
            if (mem.mem_req) begin
                arb_addr = mem.mem_addr;
                arb_stable = 1'b1;
                repeat (ack_delay - 1) begin
                    @(posedge clk50); #1;
                    if (!mem.mem_req || mem.mem_addr !== arb_addr) arb_stable = 1'b0;
                end
                mem.mem_ack = 1'b1;
                mem.mem_rdata = ack_rdata;
                @(posedge clk50); #1;
                mem.mem_ack = 1'b0;
                check("req_held_to_ack", 32'(arb_stable), 32'd1);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        repeat (10) @(posedge clk50);
        #1 rst_n = 1'b1;

        // Quiet after reset
        repeat (100) begin
            @(negedge clk50);
            check("idle_quiet", 32'({mem.mem_req, bus_data_oe, overrun, reg_wr}), 32'd0);
        end
        exp_rd(1'b1, 8'h00);
        bus_cycle(1'b1, 1'b0, 8'hFF, 8'h00);

        // JIM write with bank 1
        bus_cycle(1'b0, 1'b0, 8'hFF, 8'hC9);
        bus_cycle(1'b0, 1'b0, 8'hFE, 8'h08);
        ack_delay = 3;
        exp_mem(19'h10897, 1'b1, 8'h55);
        bus_cycle(1'b0, 1'b1, 8'h97, 8'h55);
        exp_rd(1'b1, 8'hC9);
        bus_cycle(1'b1, 1'b0, 8'hFF, 8'h00);

        // JIM disabled: FD ignored
        bus_cycle(1'b0, 1'b0, 8'hFF, 8'h00);
        bus_cycle(1'b0, 1'b1, 8'h12, 8'h34);
        exp_rd(1'b0, 8'h00);
        bus_cycle(1'b1, 1'b1, 8'h12, 8'h00);

        // JIM read in time
        bus_cycle(1'b0, 1'b0, 8'hFF, 8'hC8);
        bus_cycle(1'b0, 1'b0, 8'hFE, 8'h07);
        ack_delay = 5;
        ack_rdata = 8'hAA;
        exp_mem(19'h007D0, 1'b0, 8'h00);
        exp_rd(1'b1, 8'hAA);
        bus_cycle(1'b1, 1'b1, 8'hD0, 8'h00);
        exp_rd(1'b1, 8'h07);
        bus_cycle(1'b1, 1'b0, 8'hFE, 8'h00);

        // Engine register strobes
        exp_reg(8'hA4, 8'h3C);
        bus_cycle(1'b0, 1'b0, 8'hA4, 8'h3C);
        exp_reg(8'hA0, 8'h80);
        bus_cycle(1'b0, 1'b0, 8'hA0, 8'h80);

        // Late ack: host sees the fail byte
        ack_delay = 40;
        ack_rdata = 8'h5A;
        exp_mem(19'h00710, 1'b0, 8'h00);
        exp_rd(1'b1, 8'hFF);
        bus_cycle(1'b1, 1'b1, 8'h10, 8'h00);
        check("overrun_before", 32'(overrun), 32'd0);

        // Write while a read is still pending: dropped, overrun set
        ack_delay = 90;
        exp_mem(19'h00720, 1'b0, 8'h00);
        exp_rd(1'b1, 8'hFF);
        bus_cycle(1'b1, 1'b1, 8'h20, 8'h00);
        bus_cycle(1'b0, 1'b1, 8'h21, 8'h99);
        check("overrun_set", 32'(overrun), 32'd1);

        wait_cnt = 0;
        while (mem.mem_req && wait_cnt < 300) begin
            @(negedge clk50);
            wait_cnt++;
        end
        repeat (20) @(negedge clk50);
        check("req_released", 32'(mem.mem_req), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("mem_q_empty", 32'(mem_q.size()), 32'd0);
        check("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check("reg_q_empty", 32'(reg_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
